// File: rtl/int_divsqrt_einheit_pkg.sv
// Shared definitions for the multi-cycle integer divide / modulo / square-root unit.
package int_divsqrt_einheit_pkg;

    localparam logic [2:0] MODUS_DIVS  = 3'b000;
    localparam logic [2:0] MODUS_MODS  = 3'b001;
    localparam logic [2:0] MODUS_DIVU  = 3'b010;
    localparam logic [2:0] MODUS_MODU  = 3'b011;
    localparam logic [2:0] MODUS_ISQRT = 3'b100;

    typedef enum logic [1:0] {
        LEERLAUF    = 2'd0,
        VORBEREITEN = 2'd1,
        ITERIEREN   = 2'd2,
        KORREKTUR   = 2'd3
    } zustand_t;

    function automatic int ITER_ZYKLEN(input int breite, input int bits_pro_takt);
        return breite / bits_pro_takt;
    endfunction

endpackage

// File: rtl/divsqrt_schritt.sv
// One combinational restoring step: shift in 1 (division) or 2 (square root) bits,
// trial-subtract, keep the difference when it does not underflow.
module divsqrt_schritt #(
    parameter int BREITE = 32
) (
    input  logic [BREITE:0] rest_i,
    input  logic [1:0]      bits_i,
    input  logic            zwei_bit_i,
    input  logic [BREITE:0] subtrahend_i,
    output logic [BREITE:0] rest_o,
    output logic            bit_o
);

    logic [BREITE+2:0] geschoben;
    logic [BREITE+2:0] differenz;
    logic              unused_hoch;

    // The partial remainder never reaches bit BREITE+2, so that bit is a clean borrow flag.
    always_comb begin
        geschoben = zwei_bit_i ? {rest_i, bits_i} : {1'b0, rest_i, bits_i[1]};
        differenz = geschoben - {2'b00, subtrahend_i};
        bit_o     = ~differenz[BREITE+2];
        rest_o    = bit_o ? differenz[BREITE:0] : geschoben[BREITE:0];
    end

    assign unused_hoch = ^{geschoben[BREITE+2:BREITE+1], differenz[BREITE+1]};

endmodule

// File: rtl/int_divsqrt_einheit.sv
// Multi-cycle signed/unsigned divide, modulo and integer square root with
// defined divide-by-zero, overflow and reserved-mode results.
module int_divsqrt_einheit
    import int_divsqrt_einheit_pkg::*;
#(
    parameter int BREITE        = 32,
    parameter int BITS_PRO_TAKT = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [BREITE-1:0] Daten1,
    input  logic [BREITE-1:0] Daten2,
    input  logic [2:0]        Modus,
    input  logic              StartSignal,
    input  logic              Abbruch,
    output logic              Bereit,
    output logic              HatFertigGerechnet,
    output logic [BREITE-1:0] Ergebnis,
    output logic              DurchNullFehler,
    output logic              UngueltigerModus,
    output zustand_t          ZustandDebug
);

    // Handshake: StartSignal is taken only on an edge where Bereit=1; HatFertigGerechnet
    // pulses for one cycle when Ergebnis is valid, and Ergebnis/flags hold until the next start.
    localparam int ZW   = $clog2(BREITE + 1);
    localparam int HALB = BREITE / 2;

    zustand_t zustand_q, zustand_d;

    logic [BREITE-1:0] op1_q, op1_d, op2_q, op2_d, quo_q, quo_d, ergebnis_q, ergebnis_d;
    logic [BREITE:0]   rest_q, rest_d;
    logic [HALB-1:0]   wurzel_q, wurzel_d;
    logic [2:0]        modus_q, modus_d;
    logic [ZW-1:0]     zaehler_q, zaehler_d;
    logic              vz_quot_q, vz_quot_d, vz_rest_q, vz_rest_d;
    logic              fertig_q, fertig_d, dnf_q, dnf_d, um_q, um_d;

    logic ist_signed, ist_div, ist_mod, ist_sqrt, ist_reserviert, ueberspringen;
    logic unused_rest_msb;

    assign ist_signed     = (modus_q == MODUS_DIVS) || (modus_q == MODUS_MODS);
    assign ist_div        = (modus_q == MODUS_DIVS) || (modus_q == MODUS_DIVU);
    assign ist_mod        = (modus_q == MODUS_MODS) || (modus_q == MODUS_MODU);
    assign ist_sqrt       = (modus_q == MODUS_ISQRT);
    assign ist_reserviert = (modus_q > MODUS_ISQRT);
    assign ueberspringen  = ist_reserviert || (!ist_sqrt && (op2_q == '0));
    assign unused_rest_msb = rest_q[BREITE];

    // Step chain: all stages divide; stage 0 alone doubles as the square-root step.
    logic [BREITE:0]        kette [0:BITS_PRO_TAKT];
    logic [BITS_PRO_TAKT-1:0] q_bits;
    logic [BREITE:0]        sqrt_subtr;

    assign kette[0]   = rest_q;
    assign sqrt_subtr = {{(BREITE-HALB-1){1'b0}}, wurzel_q, 2'b01};

    for (genvar j = 0; j < BITS_PRO_TAKT; j++) begin : g_schritt
        logic [1:0]      bits;
        logic            zwei;
        logic [BREITE:0] subtr;
        if (j == 0) begin : g_erster
            assign zwei  = ist_sqrt;
            assign bits  = ist_sqrt ? quo_q[BREITE-1 -: 2] : {quo_q[BREITE-1], 1'b0};
            assign subtr = ist_sqrt ? sqrt_subtr : {1'b0, op2_q};
        end else begin : g_weitere
            assign zwei  = 1'b0;
            assign bits  = {quo_q[BREITE-1-j], 1'b0};
            assign subtr = {1'b0, op2_q};
        end
        divsqrt_schritt #(.BREITE(BREITE)) u_schritt (
            .rest_i      (kette[j]),
            .bits_i      (bits),
            .zwei_bit_i  (zwei),
            .subtrahend_i(subtr),
            .rest_o      (kette[j+1]),
            .bit_o       (q_bits[BITS_PRO_TAKT-1-j])
        );
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            zustand_q <= LEERLAUF;
        end else begin
            zustand_q <= zustand_d;
        end
    end

    always_comb begin
        zustand_d = zustand_q;
        case (zustand_q)
            LEERLAUF:    if (StartSignal) zustand_d = VORBEREITEN;
            VORBEREITEN: zustand_d = ueberspringen ? KORREKTUR : ITERIEREN;
            ITERIEREN:   if (zaehler_q == ZW'(1)) zustand_d = KORREKTUR;
            KORREKTUR:   zustand_d = LEERLAUF;
            default:     zustand_d = LEERLAUF;
        endcase
        if (Abbruch && (zustand_q != LEERLAUF)) zustand_d = LEERLAUF;
    end

    always_comb begin
        Bereit             = (zustand_q == LEERLAUF);
        HatFertigGerechnet = fertig_q;
        Ergebnis           = ergebnis_q;
        DurchNullFehler    = dnf_q;
        UngueltigerModus   = um_q;
        ZustandDebug       = zustand_q;
    end

    always_comb begin
        op1_d      = op1_q;
        op2_d      = op2_q;
        modus_d    = modus_q;
        quo_d      = quo_q;
        rest_d     = rest_q;
        wurzel_d   = wurzel_q;
        zaehler_d  = zaehler_q;
        vz_quot_d  = vz_quot_q;
        vz_rest_d  = vz_rest_q;
        ergebnis_d = ergebnis_q;
        dnf_d      = dnf_q;
        um_d       = um_q;
        fertig_d   = 1'b0;
        case (zustand_q)
            LEERLAUF: begin
                if (StartSignal) begin
                    op1_d   = Daten1;
                    op2_d   = Daten2;
                    modus_d = Modus;
                    dnf_d   = 1'b0;
                    um_d    = 1'b0;
                end
            end
            VORBEREITEN: begin
                // op1_q keeps the raw dividend for the MOD-by-zero result; op2_q becomes |divisor|.
                vz_quot_d = ist_signed & (op1_q[BREITE-1] ^ op2_q[BREITE-1]);
                vz_rest_d = ist_signed & op1_q[BREITE-1];
                quo_d     = (ist_signed && op1_q[BREITE-1]) ? -op1_q : op1_q;
                op2_d     = (ist_signed && op2_q[BREITE-1]) ? -op2_q : op2_q;
                rest_d    = '0;
                wurzel_d  = '0;
                zaehler_d = ist_sqrt ? ZW'(HALB) : ZW'(ITER_ZYKLEN(BREITE, BITS_PRO_TAKT));
            end
            ITERIEREN: begin
                zaehler_d = zaehler_q - ZW'(1);
                if (ist_sqrt) begin
                    rest_d   = kette[1];
                    quo_d    = {quo_q[BREITE-3:0], 2'b00};
                    wurzel_d = {wurzel_q[HALB-2:0], q_bits[BITS_PRO_TAKT-1]};
                end else begin
                    rest_d = kette[BITS_PRO_TAKT];
                    quo_d  = {quo_q[BREITE-BITS_PRO_TAKT-1:0], q_bits};
                end
            end
            KORREKTUR: begin
                if (!Abbruch) begin
                    fertig_d = 1'b1;
                    if (ist_reserviert) begin
                        ergebnis_d = '0;
                        um_d       = 1'b1;
                    end else if (ist_sqrt) begin
                        ergebnis_d = {{(BREITE-HALB){1'b0}}, wurzel_q};
                    end else if (op2_q == '0) begin
                        dnf_d      = 1'b1;
                        ergebnis_d = ist_div ? '1 : op1_q;
                    end else if (ist_div) begin
                        ergebnis_d = vz_quot_q ? -quo_q : quo_q;
                    end else if (ist_mod) begin
                        ergebnis_d = vz_rest_q ? -rest_q[BREITE-1:0] : rest_q[BREITE-1:0];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            op1_q      <= '0;
            op2_q      <= '0;
            modus_q    <= '0;
            quo_q      <= '0;
            rest_q     <= '0;
            wurzel_q   <= '0;
            zaehler_q  <= '0;
            vz_quot_q  <= 1'b0;
            vz_rest_q  <= 1'b0;
            ergebnis_q <= '0;
            dnf_q      <= 1'b0;
            um_q       <= 1'b0;
            fertig_q   <= 1'b0;
        end else begin
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            modus_q    <= modus_d;
            quo_q      <= quo_d;
            rest_q     <= rest_d;
            wurzel_q   <= wurzel_d;
            zaehler_q  <= zaehler_d;
            vz_quot_q  <= vz_quot_d;
            vz_rest_q  <= vz_rest_d;
            ergebnis_q <= ergebnis_d;
            dnf_q      <= dnf_d;
            um_q       <= um_d;
            fertig_q   <= fertig_d;
        end
    end

endmodule

// File: doc/int_divsqrt_einheit.md
Name: int_divsqrt_einheit

Overview:
Parametrised multi-cycle integer divide/modulo/square-root unit. Successor to the fixed 32-bit divider and square-root path in the processor ALU. Adds:
- configurable width and quotient bits per cycle
- a signed/unsigned mode
- defined divide-by-zero and overflow results
- a ready/done handshake and an abort input

The ALU instantiates it and muxes Ergebnis when FunktionsCode selects div/mod/isqrt.

Parameters:
BREITE, 32, operand/result width; even, >= 8.
BITS_PRO_TAKT, 1, quotient bits retired per iteration cycle; 1, 2 or 4; must divide BREITE.

Ports:
Clock  input  1  single clock, rising edge.
Reset  input  1  asynchronous, active-high; clears all state.
Daten1  input  BREITE  dividend / radicand.
Daten2  input  BREITE  divisor (ignored for ISQRT).
Modus  input  3  000 DIVS, 001 MODS, 010 DIVU, 011 MODU, 100 ISQRT; 101-111 reserved.
StartSignal  input  1  start request; accepted only when Bereit=1.
Abbruch  input  1  synchronous abort of a running operation.
Bereit  output  1  1 in LEERLAUF.
HatFertigGerechnet  output  1  one-cycle pulse when Ergebnis is valid.
Ergebnis  output  BREITE  result; held until the next accepted start.
DurchNullFehler  output  1  1 with the result of a div/mod whose divisor was 0; held with Ergebnis.
UngueltigerModus  output  1  1 with the result of a reserved Modus; held with Ergebnis.

Behaviour:
- Reset (async): state LEERLAUF, Bereit=1, HatFertigGerechnet=0, Ergebnis=0, both error flags 0.
- States: LEERLAUF, VORBEREITEN, ITERIEREN, KORREKTUR.
- LEERLAUF, StartSignal=1 at edge t0:
  - latch Daten1, Daten2 and Modus.
  - clear the error flags.
  - go to VORBEREITEN; Bereit=0 from t0.
- VORBEREITEN (1 cycle):
  - signed modes: take the absolute values and record the quotient sign (s1^s2) and remainder sign (s1).
  - divisor==0 or reserved Modus: skip to KORREKTUR.
  - otherwise load the iteration counter and go to ITERIEREN.
- ITERIEREN:
  - div/mod: restoring division, BITS_PRO_TAKT quotient bits per cycle, N = BREITE/BITS_PRO_TAKT cycles.
  - ISQRT: restoring digit-by-digit square root, one result bit per cycle, BREITE/2 cycles, unsigned radicand.
- KORREKTUR (1 cycle):
  - apply the signs; DIV selects the quotient, MOD selects the remainder.
  - register Ergebnis; pulse HatFertigGerechnet on the following cycle; return to LEERLAUF (Bereit=1 in the same cycle as the pulse).
- Latency L, from start edge t0 to the edge after which HatFertigGerechnet=1:
  - div/mod: N+2 (BREITE=32: 34 cycles at K=1, 18 at K=2, 10 at K=4).
  - ISQRT: BREITE/2+2.
  - div-by-zero and reserved Modus: 2.
- Rounding: division truncates toward zero. Remainder takes the sign of the dividend, and Daten1 = q*Daten2 + r holds.
- Divide-by-zero: DIVU quotient all ones; DIVS quotient -1; MODx remainder = Daten1; DurchNullFehler=1.
- Signed overflow, MIN / -1: quotient MIN, remainder 0, no error flag.
- Reserved Modus: Ergebnis=0, UngueltigerModus=1.
- StartSignal while Bereit=0: ignored; latched operands stay unchanged.
- Abbruch=1 in a non-LEERLAUF state:
  - next state LEERLAUF, no done pulse.
  - Ergebnis and the error flags keep their previous values.
- Abbruch in LEERLAUF: no effect. Abbruch and StartSignal together in LEERLAUF: the start is accepted.
- Reset mid-operation: immediate return to the reset values; no pulse.
- Inputs only need to be stable at the start edge.

Decomposition:
- Shared package: Modus codes (MODUS_DIVS ... MODUS_ISQRT), state encoding, and the function ITER_ZYKLEN(BREITE, BITS_PRO_TAKT).
- One natural sub-module, divsqrt_schritt: combinational single restoring step (trial subtract, select, shift), parametrised by BREITE. Instantiated BITS_PRO_TAKT times in a chain for division; sqrt uses one instance in 2-bit radicand mode.

Test Plan:
- DIVS 7 / -2 -> Ergebnis 0xFFFFFFFD (-3), pulse exactly 34 cycles after the start (K=1); MODS -7 % 2 -> 0xFFFFFFFF (-1).
- DIVU 0xFFFFFFFF / 3 -> 0x55555555; MODU 100 % 7 -> 2; rerun with BITS_PRO_TAKT=4 -> same results, latency 10.
- ISQRT 1000000 -> 1000; ISQRT 0xFFFFFFFF -> 0x0000FFFF; ISQRT 0 -> 0; latency 18.
- DIVU 5 / 0 -> 0xFFFFFFFF with DurchNullFehler=1 and latency 2; MODS 5 % 0 -> 5; DIVS 0x80000000 / -1 -> 0x80000000, MODS -> 0, no flag.
- Start DIVU 100/7, a second StartSignal at cycle 5 with other operands, then Abbruch at cycle 10 -> no pulse, Bereit=1 at cycle 11, Ergebnis unchanged; new DIVU 100/7 -> 14.
- Reset asserted mid-ITERIEREN, asynchronously between edges -> outputs at reset values immediately; Modus 111 -> Ergebnis 0, UngueltigerModus=1.
